rs_issue_scheduler: RTL and testbench
=====================================

# rs_issue_scheduler

Issue scheduler and slot allocator for one `reservation_station` instance. It sits between rename/dispatch and the RS.
- **Allocation:** it assigns free RS entries to incoming dispatch slots.
- **Age tracking:** it keeps an age matrix over entries.
- **Issue:** each cycle it grants the oldest ready entries to up to ISSUE_W functional-unit ports.

It drives the RS `entry_wen`, `issue_grant` and `sel_idx_*` inputs, and consumes the RS `busy_vector` and `ready_mask`.

## Interface
- RS_DEPTH, default Cfg.RS_DEPTH: number of RS entries.
- ISSUE_W, default 4: number of issue ports; matches RS read channels 0..3.
- DISPATCH_W, default 4: number of dispatch slots per cycle.
- RS_IDX_W, default $clog2(RS_DEPTH): entry index width.
- CNT_W, default 32: width of the perf counter.

- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- flush_i  in  1  pipeline flush; same cycle as the RS flush.
- disp_valid_i  in  DISPATCH_W  per-slot dispatch request.
- disp_ready_o  out  1  all valid slots accepted this cycle.
- alloc_idx_o  out  DISPATCH_W x RS_IDX_W  RS entry assigned to each slot; meaningful only when the slot is valid and accepted.
- alloc_wen_o  out  RS_DEPTH  to RS `entry_wen`.
- busy_vector_i  in  RS_DEPTH  from RS `busy_vector`.
- ready_mask_i  in  RS_DEPTH  from RS `ready_mask`.
- fu_ready_i  in  ISSUE_W  port p's FU can accept a uop this cycle.
- issue_valid_o  out  ISSUE_W  port p issues this cycle.
- sel_idx_o  out  ISSUE_W x RS_IDX_W  to RS `sel_idx_p`; 0 when the port is not issuing.
- issue_grant_o  out  RS_DEPTH  to RS `issue_grant`; equals the OR of one-hot(sel_idx_o[p]) over issuing ports.
- perf_issue_cnt_o  out  CNT_W  total uops issued since reset.

## Operation

**Free vector**
- free = ~busy_vector_i.
- Entries granted this cycle are not counted as free until the next cycle.

**Dispatch, all-or-nothing**
- disp_ready_o = (popcount(free) >= DISPATCH_W) && !flush_i.
- disp_ready_o is independent of disp_valid_i.
- On accept, valid slots in ascending slot order take free entries in ascending index order. Invalid slots consume no entry.
- alloc_wen_o has one bit per accepted slot.

**Age matrix**
- age[i][j]=1 means entry i is older than entry j. Diagonal is always 0.
- Entry e allocated in slot s at the clock edge:
  - age[e][j] <= 0 for every j that was busy or was allocated in a lower slot that cycle.
  - age[j][e] <= 1 for those same j.
  - age[e][j] <= 1 and age[j][e] <= 0 for every other j.
- Rows and columns of entries that are not busy are don't-care and are overwritten on allocation.

**Issue selection**
- Selection is combinational, in port order 0..ISSUE_W-1.
- Candidate set: cand = ready_mask_i.
- Port p with fu_ready_i[p]=1 picks the oldest entry in cand: the entry i in cand with no j in cand where age[j][i]=1. It then removes i from cand.
- A port with fu_ready_i[p]=0 skips and does not consume a candidate.
- If cand is empty, issue_valid_o[p]=0.

**Flush**
- flush_i=1 forces issue_grant_o=0, issue_valid_o=0, alloc_wen_o=0 and disp_ready_o=0.
- The age matrix clears to 0 at the next edge.

**Perf counter**
- perf_issue_cnt_o += popcount(issue_valid_o) each cycle.
- It wraps modulo 2^CNT_W.

## Timing
- Issue and allocation outputs are combinational from inputs plus age state, with zero-cycle latency. The RS samples them at the same edge.
- An entry written at edge t becomes busy at t. It can be granted no earlier than the cycle after t, and only when its ready_mask bit is set.
- Reset values: age = 0, perf_issue_cnt_o = 0.
- With RS reset (busy = 0, ready = 0): issue_valid_o = 0, issue_grant_o = 0, sel_idx_o = 0, alloc_wen_o = 0, and disp_ready_o = 1 when RS_DEPTH >= DISPATCH_W.
- Reset asserted mid-operation clears state immediately. Outputs follow the reset RS inputs.
- Allocation and grant on the same entry in the same cycle cannot occur, because allocation uses only non-busy entries.
- When the RS is full (free = 0): disp_ready_o = 0, and issue proceeds normally.

## Structure
- No new package types. RS_DEPTH comes from config_pkg::cfg_t Cfg.
- Sub-module `rs_oldest_select` (combinational): takes cand and the age matrix, outputs a one-hot oldest entry plus a found flag. It is instantiated ISSUE_W times and chained through the cand masks.
- Allocation uses a prefix-count priority encoder, inline.

## Test plan
- **Reset then dispatch:** reset, then dispatch 4 valid slots with RS_DEPTH=16, all free -> alloc_idx_o = 0,1,2,3, alloc_wen_o=0x000F, disp_ready_o=1.
- **Sparse dispatch:** busy=0x000F, disp_valid_i=4'b1010 -> slot1 gets entry 4, slot3 gets entry 5, alloc_wen_o=0x0030.
- **Age order:** allocate entries 7 then 2 in successive cycles, both ready, fu_ready_i=4'b0001 -> port0 sel_idx=7, issue_grant_o=0x0080. Next cycle sel_idx=2.
- **Port skipping:** ready entries 1,3,5 allocated in that order, fu_ready_i=4'b1010 -> port1 gets 1, port3 gets 3, entry 5 is not issued, issue_valid_o=4'b1010.
- **Full and flush:** busy=0xFFFF -> disp_ready_o=0. Assert flush_i with ready_mask nonzero -> issue_grant_o=0, and age is 0 after the edge.
- **Perf counter:** 3 cycles issuing 4,2,0 uops -> perf_issue_cnt_o=6.

Source files
------------

// File: rtl/config_pkg.sv
// Codebase-wide configuration record; the scheduler takes its RS depth from here.
package config_pkg;

  typedef struct packed {
    int unsigned RS_DEPTH;
  } cfg_t;

  localparam cfg_t DEFAULT_CFG = '{RS_DEPTH: 16};

endpackage

// File: rtl/rs_issue_scheduler_pkg.sv
// Default widths shared by the issue scheduler and its oldest-entry selector.
package rs_issue_scheduler_pkg;

  localparam int unsigned ISSUE_W_DEF    = 4;
  localparam int unsigned DISPATCH_W_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 32;

endpackage

// File: rtl/rs_issue_scheduler_oldest_select.sv
// rs_oldest_select: picks the oldest entry of a candidate mask using the age matrix.
module rs_oldest_select
  import rs_issue_scheduler_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]        cand_i,
  input  logic [N-1:0][N-1:0] age_i,
  output logic [N-1:0]        oldest_oh_o,
  output logic                found_o
);

  logic [N-1:0] w_oldest;

  // An entry is oldest when no other candidate is marked older than it.
  always_comb begin
    w_oldest = '0;
    for (int i = 0; i < N; i++) begin
      w_oldest[i] = cand_i[i];
      for (int j = 0; j < N; j++) begin
        if (cand_i[j] && age_i[j][i]) w_oldest[i] = 1'b0;
      end
    end
  end

  // Keep a single winner; ties only arise with a cleared matrix and go to the lowest index.
  always_comb begin
    oldest_oh_o = '0;
    found_o     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_oldest[i] && !found_o) begin
        oldest_oh_o[i] = 1'b1;
        found_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station slot allocator, age tracker and oldest-first issue selector.
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter config_pkg::cfg_t Cfg        = config_pkg::DEFAULT_CFG,
  parameter int unsigned      RS_DEPTH   = Cfg.RS_DEPTH,
  parameter int unsigned      ISSUE_W    = ISSUE_W_DEF,
  parameter int unsigned      DISPATCH_W = DISPATCH_W_DEF,
  parameter int unsigned      RS_IDX_W   = $clog2(RS_DEPTH),
  parameter int unsigned      CNT_W      = CNT_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [DISPATCH_W-1:0]               disp_valid_i,
  output logic                                disp_ready_o,
  output logic [DISPATCH_W-1:0][RS_IDX_W-1:0] alloc_idx_o,
  output logic [RS_DEPTH-1:0]                 alloc_wen_o,
  input  logic [RS_DEPTH-1:0]                 busy_vector_i,
  input  logic [RS_DEPTH-1:0]                 ready_mask_i,
  input  logic [ISSUE_W-1:0]                  fu_ready_i,
  output logic [ISSUE_W-1:0]                  issue_valid_o,
  output logic [ISSUE_W-1:0][RS_IDX_W-1:0]    sel_idx_o,
  output logic [RS_DEPTH-1:0]                 issue_grant_o,
  output logic [CNT_W-1:0]                    perf_issue_cnt_o
);

  localparam int unsigned CNT_BITS = $clog2(RS_DEPTH + 1);

  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]   r_age;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]   w_age_nxt;
  logic [CNT_W-1:0]                    r_perf_cnt;
  logic [RS_DEPTH-1:0]                 w_free;
  logic [RS_DEPTH-1:0][CNT_BITS-1:0]   w_rank;
  logic [CNT_BITS-1:0]                 w_free_cnt;
  logic [CNT_BITS-1:0]                 w_vcnt;
  logic [DISPATCH_W-1:0][RS_DEPTH-1:0] w_slot_oh;
  logic [RS_DEPTH-1:0]                 w_older;
  logic [ISSUE_W-1:0][RS_DEPTH-1:0]    w_port_grant;

  assign w_free = ~busy_vector_i;

  // Prefix count: rank of each free entry among free entries below it.
  always_comb begin
    w_rank     = '0;
    w_free_cnt = '0;
    for (int e = 0; e < RS_DEPTH; e++) begin
      w_rank[e]  = w_free_cnt;
      w_free_cnt = w_free_cnt + CNT_BITS'(w_free[e]);
    end
  end

  assign disp_ready_o = (32'(w_free_cnt) >= DISPATCH_W) && !flush_i;

  // Valid slot k-th in order takes the free entry of rank k.
  always_comb begin
    w_slot_oh   = '0;
    alloc_idx_o = '0;
    w_vcnt      = '0;
    for (int s = 0; s < DISPATCH_W; s++) begin
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (w_free[e] && (w_rank[e] == w_vcnt)) begin
          w_slot_oh[s][e] = disp_valid_i[s];
          alloc_idx_o[s]  = RS_IDX_W'(e);
        end
      end
      w_vcnt = w_vcnt + CNT_BITS'(disp_valid_i[s]);
    end
  end

  // Write enables for accepted slots only.
  always_comb begin
    alloc_wen_o = '0;
    for (int s = 0; s < DISPATCH_W; s++) begin
      if (disp_ready_o) alloc_wen_o = alloc_wen_o | w_slot_oh[s];
    end
  end

  // New entries are younger than busy entries and lower-slot allocations, older than the rest.
  always_comb begin
    w_age_nxt = r_age;
    w_older   = busy_vector_i;
    for (int s = 0; s < DISPATCH_W; s++) begin
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (disp_ready_o && w_slot_oh[s][e]) begin
          for (int j = 0; j < RS_DEPTH; j++) begin
            w_age_nxt[e][j] = !w_older[j] && (j != e);
            w_age_nxt[j][e] = w_older[j] && (j != e);
          end
        end
      end
      if (disp_ready_o) w_older = w_older | w_slot_oh[s];
    end
  end

  // Age matrix register; flush wipes all ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (flush_i) begin
      r_age <= '0;
    end else begin
      r_age <= w_age_nxt;
    end
  end

  // Issue ports chained in order; a port without a ready FU passes the candidates through.
  for (genvar p = 0; p < ISSUE_W; p++) begin : g_port
    logic [RS_DEPTH-1:0] w_cand_in;
    logic [RS_DEPTH-1:0] w_cand_out;
    logic [RS_DEPTH-1:0] w_oh;
    logic                w_found;
    logic                w_issue;
    logic [RS_IDX_W-1:0] w_idx;

    if (p == 0) begin : g_head
      assign w_cand_in = ready_mask_i;
    end else begin : g_link
      assign w_cand_in = g_port[p-1].w_cand_out;
    end

    rs_oldest_select #(.N(RS_DEPTH)) u_sel (
      .cand_i      (w_cand_in),
      .age_i       (r_age),
      .oldest_oh_o (w_oh),
      .found_o     (w_found)
    );

    assign w_issue    = fu_ready_i[p] && w_found && !flush_i;
    assign w_cand_out = fu_ready_i[p] ? (w_cand_in & ~w_oh) : w_cand_in;

    // One-hot to index for the RS read channel.
    always_comb begin
      w_idx = '0;
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (w_oh[e]) w_idx = RS_IDX_W'(e);
      end
    end

    assign issue_valid_o[p] = w_issue;
    assign sel_idx_o[p]     = w_issue ? w_idx : '0;
    assign w_port_grant[p]  = w_issue ? w_oh : '0;
  end

  // Merge per-port grants for the RS.
  always_comb begin
    issue_grant_o = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      issue_grant_o = issue_grant_o | w_port_grant[p];
    end
  end

  // Running count of issued uops, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt <= '0;
    end else begin
      r_perf_cnt <= r_perf_cnt + CNT_W'($countones(issue_valid_o));
    end
  end

  assign perf_issue_cnt_o = r_perf_cnt;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: allocation vector table plus issue/age/flush/perf sequences.
module tb_rs_issue_scheduler;

  localparam int unsigned D  = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned XW = 4;
  localparam int unsigned CW = 32;

  localparam int K_RDY  = 0;
  localparam int K_WEN  = 1;
  localparam int K_IDX  = 2;
  localparam int K_IV   = 3;
  localparam int K_GNT  = 4;
  localparam int K_SEL  = 5;
  localparam int K_PERF = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush_i;
  logic [DW-1:0]          disp_valid_i;
  logic                   disp_ready_o;
  logic [DW-1:0][XW-1:0]  alloc_idx_o;
  logic [D-1:0]           alloc_wen_o;
  logic [D-1:0]           busy_vector_i;
  logic [D-1:0]           ready_mask_i;
  logic [IW-1:0]          fu_ready_i;
  logic [IW-1:0]          issue_valid_o;
  logic [IW-1:0][XW-1:0]  sel_idx_o;
  logic [D-1:0]           issue_grant_o;
  logic [CW-1:0]          perf_issue_cnt_o;

  rs_issue_scheduler #(
    .Cfg        (config_pkg::DEFAULT_CFG),
    .ISSUE_W    (IW),
    .DISPATCH_W (DW),
    .CNT_W      (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .disp_valid_i     (disp_valid_i),
    .disp_ready_o     (disp_ready_o),
    .alloc_idx_o      (alloc_idx_o),
    .alloc_wen_o      (alloc_wen_o),
    .busy_vector_i    (busy_vector_i),
    .ready_mask_i     (ready_mask_i),
    .fu_ready_i       (fu_ready_i),
    .issue_valid_o    (issue_valid_o),
    .sel_idx_o        (sel_idx_o),
    .issue_grant_o    (issue_grant_o),
    .perf_issue_cnt_o (perf_issue_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          slot;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [15:0]     busy;
    logic [3:0]      valid;
    logic            flush;
    logic            rdy;
    logic [15:0]     wen;
    logic [3:0][3:0] idx;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] actual(input int kind, input int slot);
    case (kind)
      K_RDY:   return 32'(disp_ready_o);
      K_WEN:   return 32'(alloc_wen_o);
      K_IDX:   return 32'(alloc_idx_o[slot]);
      K_IV:    return 32'(issue_valid_o);
      K_GNT:   return 32'(issue_grant_o);
      K_SEL:   return 32'(sel_idx_o[slot]);
      K_PERF:  return perf_issue_cnt_o;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_RDY:   return "disp_ready";
      K_WEN:   return "alloc_wen";
      K_IDX:   return "alloc_idx";
      K_IV:    return "issue_valid";
      K_GNT:   return "issue_grant";
      K_SEL:   return "sel_idx";
      K_PERF:  return "perf_cnt";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_v(input int kind, input int slot, input logic [31:0] v);
    sb_t e;
    e.kind = kind;
    e.slot = slot;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Compare every pending expectation against the live outputs.
  task automatic check_now(input string tag);
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      sb_t e;
      e   = sb_q.pop_front();
      act = actual(e.kind, e.slot);
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s %s[%0d]: got 0x%0h expected 0x%0h", tag, kname(e.kind), e.slot, act, e.exp);
      end
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    check_now(tag);
  endtask

  task automatic apply(input logic [15:0] b, input logic [15:0] r, input logic [3:0] v,
                       input logic [3:0] f, input logic fl);
    @(posedge clk);
    #1;
    busy_vector_i = b;
    ready_mask_i  = r;
    disp_valid_i  = v;
    fu_ready_i    = f;
    flush_i       = fl;
  endtask

  task automatic expect_issue(input logic [3:0] iv, input logic [15:0] gnt,
                              input logic [3:0][3:0] sel);
    expect_v(K_IV, 0, 32'(iv));
    expect_v(K_GNT, 0, 32'(gnt));
    for (int p = 0; p < 4; p++) expect_v(K_SEL, p, 32'(sel[p]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0000, 4'b1111, 1'b0, 1'b1, 16'h000F, {4'd3, 4'd2, 4'd1, 4'd0}};
    tbl[1] = '{16'h000F, 4'b1010, 1'b0, 1'b1, 16'h0030, {4'd5, 4'd0, 4'd4, 4'd0}};
    tbl[2] = '{16'hFFFF, 4'b1111, 1'b0, 1'b0, 16'h0000, {4'd0, 4'd0, 4'd0, 4'd0}};
    tbl[3] = '{16'hFF0F, 4'b0101, 1'b0, 1'b1, 16'h0030, {4'd0, 4'd5, 4'd0, 4'd4}};
    tbl[4] = '{16'hFF1F, 4'b1111, 1'b0, 1'b0, 16'h0000, {4'd0, 4'd0, 4'd0, 4'd0}};
    tbl[5] = '{16'h0000, 4'b1111, 1'b1, 1'b0, 16'h0000, {4'd0, 4'd0, 4'd0, 4'd0}};
    tbl[6] = '{16'h5555, 4'b1001, 1'b0, 1'b1, 16'h000A, {4'd3, 4'd0, 4'd0, 4'd1}};
    tbl[7] = '{16'h0000, 4'b0000, 1'b0, 1'b1, 16'h0000, {4'd0, 4'd0, 4'd0, 4'd0}};

    rst_n         = 1'b0;
    flush_i       = 1'b0;
    disp_valid_i  = '0;
    busy_vector_i = '0;
    ready_mask_i  = '0;
    fu_ready_i    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state with an empty RS.
    expect_v(K_RDY, 0, 32'd1);
    expect_v(K_WEN, 0, 32'd0);
    expect_v(K_PERF, 0, 32'd0);
    expect_issue(4'b0000, 16'h0000, '0);
    drain("reset");

    // Allocation vectors.
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].busy, 16'h0000, tbl[i].valid, 4'b0000, tbl[i].flush);
      expect_v(K_RDY, 0, 32'(tbl[i].rdy));
      expect_v(K_WEN, 0, 32'(tbl[i].wen));
      expect_v(K_IV, 0, 32'd0);
      for (int s = 0; s < 4; s++) begin
        if (tbl[i].valid[s] && tbl[i].rdy) expect_v(K_IDX, s, 32'(tbl[i].idx[s]));
      end
      drain($sformatf("vec%0d", i));
    end

    // Age order: 7 allocated before 2.
    apply(16'h007F, 16'h0000, 4'b0001, 4'b0000, 1'b0);
    expect_v(K_IDX, 0, 32'd7);
    expect_v(K_WEN, 0, 32'h0080);
    drain("age_alloc7");
    apply(16'h00FB, 16'h0000, 4'b0001, 4'b0000, 1'b0);
    expect_v(K_IDX, 0, 32'd2);
    expect_v(K_WEN, 0, 32'h0004);
    drain("age_alloc2");
    apply(16'h00FF, 16'h0084, 4'b0000, 4'b0001, 1'b0);
    expect_issue(4'b0001, 16'h0080, {4'd0, 4'd0, 4'd0, 4'd7});
    drain("age_issue7");
    apply(16'h007F, 16'h0004, 4'b0000, 4'b0001, 1'b0);
    expect_issue(4'b0001, 16'h0004, {4'd0, 4'd0, 4'd0, 4'd2});
    expect_v(K_PERF, 0, 32'd1);
    drain("age_issue2");

    // Port skipping: 1, 3, 5 allocated in that order.
    apply(16'h00FD, 16'h0000, 4'b0001, 4'b0000, 1'b0);
    expect_v(K_IDX, 0, 32'd1);
    expect_v(K_PERF, 0, 32'd2);
    drain("skip_alloc1");
    apply(16'h00F7, 16'h0000, 4'b0001, 4'b0000, 1'b0);
    expect_v(K_IDX, 0, 32'd3);
    drain("skip_alloc3");
    apply(16'h00DF, 16'h0000, 4'b0001, 4'b0000, 1'b0);
    expect_v(K_IDX, 0, 32'd5);
    expect_v(K_WEN, 0, 32'h0020);
    drain("skip_alloc5");
    apply(16'h00FF, 16'h002A, 4'b0000, 4'b1010, 1'b0);
    expect_issue(4'b1010, 16'h000A, {4'd3, 4'd0, 4'd1, 4'd0});
    drain("skip_issue");

    // Full RS still issues; 7 is older than 2.
    apply(16'hFFFF, 16'h0084, 4'b1111, 4'b0011, 1'b0);
    expect_v(K_RDY, 0, 32'd0);
    expect_v(K_WEN, 0, 32'd0);
    expect_issue(4'b0011, 16'h0084, {4'd0, 4'd0, 4'd2, 4'd7});
    drain("full");
    apply(16'hFFFF, 16'h0084, 4'b1111, 4'b0011, 1'b1);
    expect_v(K_RDY, 0, 32'd0);
    expect_v(K_WEN, 0, 32'd0);
    expect_issue(4'b0000, 16'h0000, '0);
    drain("flush");
    // Cleared ages leave 2 and 7 unordered; the tie goes to the lower index.
    apply(16'hFFFF, 16'h0084, 4'b0000, 4'b0011, 1'b0);
    expect_issue(4'b0011, 16'h0084, {4'd0, 4'd0, 4'd7, 4'd2});
    expect_v(K_PERF, 0, 32'd6);
    drain("post_flush");

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #2;
    rst_n         = 1'b0;
    busy_vector_i = '0;
    ready_mask_i  = '0;
    disp_valid_i  = '0;
    fu_ready_i    = '0;
    #1;
    expect_v(K_PERF, 0, 32'd0);
    expect_v(K_RDY, 0, 32'd1);
    expect_issue(4'b0000, 16'h0000, '0);
    check_now("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Perf counter: 4, 2, then 0 uops.
    apply(16'hFFFF, 16'h00F0, 4'b0000, 4'b1111, 1'b0);
    expect_v(K_IV, 0, 32'hF);
    expect_v(K_GNT, 0, 32'h00F0);
    expect_v(K_PERF, 0, 32'd0);
    drain("perf4");
    apply(16'hFFFF, 16'h0300, 4'b0000, 4'b1111, 1'b0);
    expect_v(K_IV, 0, 32'h3);
    expect_v(K_GNT, 0, 32'h0300);
    expect_v(K_PERF, 0, 32'd4);
    drain("perf2");
    apply(16'hFFFF, 16'h0000, 4'b0000, 4'b1111, 1'b0);
    expect_v(K_IV, 0, 32'h0);
    expect_v(K_PERF, 0, 32'd6);
    drain("perf0");
    apply(16'hFFFF, 16'h0000, 4'b0000, 4'b0000, 1'b0);
    expect_v(K_PERF, 0, 32'd6);
    drain("perf_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
